// File: rtl/dds_regs_pkg.sv
// Shared definitions for the DDS register block: register offsets, buffer indices,
// CTRL bit positions, AXI response codes, FSM state types and small helper functions.
// Ports: none (package).
package dds_regs_pkg;

  // Byte offsets of the register map.
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_THETAS = 8'h04;
  localparam logic [7:0] OFF_DELTAS = 8'h08;
  localparam logic [7:0] OFF_AMPLS  = 8'h0C;
  localparam logic [7:0] OFF_LNGTH  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam logic [7:0] OFF_DIV    = 8'h18;

  // Circular-buffer index presented on o_dds_addrs.
  localparam logic [31:0] BUF_THETAS = 32'd0;
  localparam logic [31:0] BUF_DELTAS = 32'd1;
  localparam logic [31:0] BUF_AMPLS  = 32'd2;

  localparam int CTRL_RST_BIT  = 0;
  localparam int CTRL_STRT_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_THETAS, SEL_DELTAS, SEL_AMPLS,
    SEL_LNGTH, SEL_STATUS, SEL_DIV, SEL_NONE
  } reg_sel_e;

  // Byte-lane merge of a write into an existing register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Map a word-aligned byte offset to a register selector.
  function automatic reg_sel_e offset_sel(input logic [7:0] off);
    case (off)
      OFF_CTRL:   return SEL_CTRL;
      OFF_THETAS: return SEL_THETAS;
      OFF_DELTAS: return SEL_DELTAS;
      OFF_AMPLS:  return SEL_AMPLS;
      OFF_LNGTH:  return SEL_LNGTH;
      OFF_STATUS: return SEL_STATUS;
      OFF_DIV:    return SEL_DIV;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dds_sample_timer.sv
// Sample-enable timer: counts 0..div while en, pulse is high (combinationally) in the cycle count==div.
// Ports: clk, a_rst_n (async active-low), clr (zero the count), en (run), div[31:0] (compare value), pulse.
// A div lowered below the running count is only seen after the count wraps through 2^32.
module dds_sample_timer (
  input  logic        clk,
  input  logic        a_rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] div,
  output logic        pulse
);

  logic [31:0] r_cnt;
  logic        w_hit;

  assign w_hit = (r_cnt == div);
  assign pulse = en && w_hit;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_cnt <= '0;
    end else if (clr || !en) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/dds_axil_regs.sv
// AXI4-Lite register slave for the DDS core: owns the register map, turns data-register writes into
// one-cycle push strobes, keeps saturating push counters and runs the sample-enable timer.
// Ports: clk, a_rst_n, AXI4-Lite slave s_*, DDS core side o_dds_* (registers, push strobe/index, sample pulse).
module dds_axil_regs
  import dds_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] DIV_RESET  = 32'd1023,
  parameter int          CNT_MAX    = 512
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [31:0]           o_dds_addrs,
  output logic                  o_dds_write,
  output logic [31:0]           o_dds_ctrl_reg,
  output logic [31:0]           o_dds_thetas_reg,
  output logic [31:0]           o_dds_deltas_reg,
  output logic [31:0]           o_dds_ampls_reg,
  output logic [31:0]           o_dds_lngth_reg,
  output logic                  o_dds_sample_en
);

  localparam logic [9:0] CNT_SAT = 10'(CNT_MAX);

  // Decode ignores bits [1:0]; anything above the 8-bit map is unmapped.
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    w[1:0] = 2'b00;
    if (w[31:8] != 24'd0) return SEL_NONE;
    return offset_sel(w[7:0]);
  endfunction

  // Register file
  logic [31:0] r_ctrl, r_thetas, r_deltas, r_ampls, r_lngth, r_div;
  logic [9:0]  r_cnt_th, r_cnt_de, r_cnt_am;
  logic        r_push_vld;
  logic [31:0] r_push_idx;

  // Keeps READYs low while reset is asserted and for the first edge after release.
  logic r_rst_done;

  // Write channel
  w_state_e        r_wstate, w_wstate_nxt;
  logic            r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [1:0]      r_bresp;
  logic            w_aw_hs, w_w_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_cm_addr;
  logic [31:0]     w_cm_data, w_wr_old, w_merged;
  logic [3:0]      w_cm_strb;
  reg_sel_e        w_wsel;
  logic            w_wr_ok;
  logic            w_start;

  // Read channel
  r_state_e        r_rstate, w_rstate_nxt;
  logic [31:0]     r_rdata, w_rd_dat;
  logic [1:0]      r_rresp;
  logic            w_ar_hs, w_rd_ok;
  reg_sel_e        w_rsel;

  logic            w_pulse;

  assign w_start = r_ctrl[CTRL_STRT_BIT];

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) r_rst_done <= 1'b0;
    else          r_rst_done <= 1'b1;
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_awready = r_rst_done && !r_aw_held;
        s_wready  = r_rst_done && !r_w_held;
      end
      W_RESP:  s_bvalid = 1'b1;
      default: ;
    endcase
  end

  assign w_aw_hs = s_awvalid && s_awready;
  assign w_w_hs  = s_wvalid && s_wready;

  // Commit on the edge where the second of AW/W is in hand (held or handshaking now).
  assign w_commit  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_cm_addr = r_aw_held ? r_awaddr : s_awaddr;
  assign w_cm_data = r_w_held  ? r_wdata  : s_wdata;
  assign w_cm_strb = r_w_held  ? r_wstrb  : s_wstrb;
  assign w_wsel    = decode(w_cm_addr);
  assign w_merged  = strb_merge(w_wr_old, w_cm_data, w_cm_strb);

  always_comb begin
    w_wr_ok  = 1'b0;
    w_wr_old = '0;
    case (w_wsel)
      SEL_CTRL:   begin w_wr_ok = 1'b1;     w_wr_old = r_ctrl;   end
      SEL_THETAS: begin w_wr_ok = !w_start; w_wr_old = r_thetas; end
      SEL_DELTAS: begin w_wr_ok = !w_start; w_wr_old = r_deltas; end
      SEL_AMPLS:  begin w_wr_ok = !w_start; w_wr_old = r_ampls;  end
      SEL_LNGTH:  begin w_wr_ok = 1'b1;     w_wr_old = r_lngth;  end
      SEL_DIV:    begin w_wr_ok = 1'b1;     w_wr_old = r_div;    end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end
    end
  end

  // ---------------- register file / push strobe ----------------
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_ctrl     <= '0;
      r_thetas   <= '0;
      r_deltas   <= '0;
      r_ampls    <= '0;
      r_lngth    <= '0;
      r_div      <= DIV_RESET;
      r_cnt_th   <= '0;
      r_cnt_de   <= '0;
      r_cnt_am   <= '0;
      r_push_vld <= 1'b0;
      r_push_idx <= '0;
    end else begin
      // CTRL.rst lives for one cycle only; that cycle also clears the counters.
      r_ctrl[CTRL_RST_BIT] <= 1'b0;
      r_push_vld           <= 1'b0;
      if (r_ctrl[CTRL_RST_BIT]) begin
        r_cnt_th <= '0;
        r_cnt_de <= '0;
        r_cnt_am <= '0;
      end
      if (w_commit && w_wr_ok) begin
        case (w_wsel)
          SEL_CTRL: r_ctrl <= w_merged;
          SEL_THETAS: begin
            r_thetas   <= w_merged;
            r_push_vld <= 1'b1;
            r_push_idx <= BUF_THETAS;
            if (r_cnt_th < CNT_SAT) r_cnt_th <= r_cnt_th + 10'd1;
          end
          SEL_DELTAS: begin
            r_deltas   <= w_merged;
            r_push_vld <= 1'b1;
            r_push_idx <= BUF_DELTAS;
            if (r_cnt_de < CNT_SAT) r_cnt_de <= r_cnt_de + 10'd1;
          end
          SEL_AMPLS: begin
            r_ampls    <= w_merged;
            r_push_vld <= 1'b1;
            r_push_idx <= BUF_AMPLS;
            if (r_cnt_am < CNT_SAT) r_cnt_am <= r_cnt_am + 10'd1;
          end
          SEL_LNGTH: r_lngth <= w_merged;
          SEL_DIV:   r_div   <= w_merged;
          default:   ;
        endcase
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE:  s_arready = r_rst_done;
      R_DATA:  s_rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign w_ar_hs = s_arvalid && s_arready;
  assign w_rsel  = decode(s_araddr);

  always_comb begin
    w_rd_ok  = 1'b1;
    w_rd_dat = '0;
    case (w_rsel)
      SEL_CTRL:   w_rd_dat = r_ctrl & ~(32'd1 << CTRL_RST_BIT);
      SEL_THETAS: w_rd_dat = r_thetas;
      SEL_DELTAS: w_rd_dat = r_deltas;
      SEL_AMPLS:  w_rd_dat = r_ampls;
      SEL_LNGTH:  w_rd_dat = r_lngth;
      SEL_STATUS: w_rd_dat = {w_start, 1'b0, r_cnt_am, r_cnt_de, r_cnt_th};
      SEL_DIV:    w_rd_dat = r_div;
      default:    w_rd_ok  = 1'b0;
    endcase
  end

  // Captured from pre-edge register values, so a same-edge write commit is not visible here.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_dat;
      r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- sample timer ----------------
  dds_sample_timer u_timer (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .clr     (r_ctrl[CTRL_RST_BIT]),
    .en      (w_start),
    .div     (r_div),
    .pulse   (w_pulse)
  );

  assign s_bresp          = r_bresp;
  assign s_rdata          = r_rdata;
  assign s_rresp          = r_rresp;
  assign o_dds_addrs      = r_push_idx;
  assign o_dds_write      = r_push_vld;
  assign o_dds_ctrl_reg   = r_ctrl;
  assign o_dds_thetas_reg = r_thetas;
  assign o_dds_deltas_reg = r_deltas;
  assign o_dds_ampls_reg  = r_ampls;
  assign o_dds_lngth_reg  = r_lngth;
  assign o_dds_sample_en  = w_pulse;

endmodule

// File: tb/tb_dds_axil_regs.sv
// Directed bench for dds_axil_regs: AXI4-Lite writes/reads with hand-computed expectations.
// Ports: none (top-level bench).
module tb_dds_axil_regs;

  logic        clk = 1'b0;
  logic        a_rst_n;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] o_dds_addrs, o_dds_ctrl_reg, o_dds_thetas_reg, o_dds_deltas_reg;
  logic [31:0] o_dds_ampls_reg, o_dds_lngth_reg;
  logic        o_dds_write, o_dds_sample_en;

  int vecs = 0;
  int errs = 0;
  int push_cnt = 0;
  int rst_hi_cnt = 0;
  int cyc = 0;

  dds_axil_regs #(.ADDR_WIDTH(8), .DIV_RESET(32'd1023), .CNT_MAX(512)) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o_dds_addrs(o_dds_addrs), .o_dds_write(o_dds_write),
    .o_dds_ctrl_reg(o_dds_ctrl_reg), .o_dds_thetas_reg(o_dds_thetas_reg),
    .o_dds_deltas_reg(o_dds_deltas_reg), .o_dds_ampls_reg(o_dds_ampls_reg),
    .o_dds_lngth_reg(o_dds_lngth_reg), .o_dds_sample_en(o_dds_sample_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (o_dds_write) push_cnt++;
    if (o_dds_ctrl_reg[0]) rst_hi_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic wr, output logic [31:0] idx);
    bit aw_hs, w_hs, aw_done, w_done;
    int n;
    resp = 2'b11; wr = 1'b0; idx = '1;
    @(posedge clk); #1;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin s_wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!s_bvalid && n < 20);
    if (!s_bvalid) begin
      vecs++; errs++;
      $display("FAIL write_timeout addr=%h: bvalid=%b, required 1", addr, s_bvalid);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
    end else begin
      resp = s_bresp; wr = o_dds_write; idx = o_dds_addrs;
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n;
    data = '1; resp = 2'b11;
    @(posedge clk); #1;
    s_araddr = addr; s_arvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = s_arready;
      @(posedge clk); #1;
      n++;
    end
    s_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_rvalid && n < 20);
    if (!s_rvalid) begin
      vecs++; errs++;
      $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", addr, s_rvalid);
    end else begin
      data = s_rdata; resp = s_rresp;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_pulse(output int t, output bit ok);
    int n;
    ok = 0; t = -1; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (o_dds_sample_en) begin ok = 1; t = cyc; end
      n++;
    end
    if (!ok) begin
      vecs++; errs++;
      $display("FAIL pulse_timeout: no sample_en within 40 cycles, required a pulse");
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    a_rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_araddr = '0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, o_dds_write, o_dds_sample_en} !== 7'b0) begin
      errs++;
      $display("FAIL reset_hs: rdy/vld/strobes=%b, required 0000000",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, o_dds_write, o_dds_sample_en});
    end
    vecs++;
    if ((o_dds_ctrl_reg | o_dds_thetas_reg | o_dds_deltas_reg | o_dds_ampls_reg | o_dds_lngth_reg | o_dds_addrs) !== 32'h0) begin
      errs++;
      $display("FAIL reset_regs: ctrl=%h th=%h de=%h am=%h ln=%h ad=%h, required all 0",
               o_dds_ctrl_reg, o_dds_thetas_reg, o_dds_deltas_reg, o_dds_ampls_reg, o_dds_lngth_reg, o_dds_addrs);
    end
    @(posedge clk); #1 a_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errs++;
      $display("FAIL post_reset_ready: aw/w/ar ready=%b, required 111", {s_awready, s_wready, s_arready});
    end
    axi_read(8'h18, d, r);
    vecs++;
    if (d !== 32'd1023 || r !== 2'b00) begin
      errs++; $display("FAIL reset_div: data=%h resp=%b, required 000003ff/00", d, r);
    end
    axi_read(8'h14, d, r);
    vecs++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errs++; $display("FAIL reset_status: data=%h resp=%b, required 0/00", d, r);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] r; logic wr; logic [31:0] idx, d; int p0;
    p0 = push_cnt;
    axi_write(8'h04, 32'h0000_1234, 4'hF, r, wr, idx);
    vecs++;
    if (r !== 2'b00 || wr !== 1'b1 || idx !== 32'd0) begin
      errs++; $display("FAIL same_cycle_push: resp=%b write=%b addrs=%0d, required 00/1/0", r, wr, idx);
    end
    vecs++;
    if (o_dds_thetas_reg !== 32'h1234 || push_cnt - p0 !== 1) begin
      errs++; $display("FAIL same_cycle_reg: thetas=%h pulses=%0d, required 00001234/1", o_dds_thetas_reg, push_cnt - p0);
    end
    axi_read(8'h14, d, r);
    vecs++;
    if (d[9:0] !== 10'd1) begin
      errs++; $display("FAIL same_cycle_status: thetas count=%0d, required 1", d[9:0]);
    end
    // byte lanes 0 and 2 only
    axi_write(8'h04, 32'hAABB_CCDD, 4'b0101, r, wr, idx);
    vecs++;
    if (o_dds_thetas_reg !== 32'h00BB_12DD || r !== 2'b00) begin
      errs++; $display("FAIL wstrb_merge: thetas=%h resp=%b, required 00bb12dd/00", o_dds_thetas_reg, r);
    end
  endtask

  task automatic test_w_leads();
    int p0; bit bad_ready, bad_bvalid, bad_first;
    p0 = push_cnt; bad_ready = 0; bad_bvalid = 0; bad_first = 0;
    s_bready = 1'b0;
    @(posedge clk); #1;
    s_wdata = 32'h7FFF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge clk); #1 s_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 s_awaddr = 8'h0C; s_awvalid = 1'b1;
    @(posedge clk); #1 s_awvalid = 1'b0;
    // Offer a second write while the response is pending.
    s_awaddr = 8'h04; s_awvalid = 1'b1; s_wdata = 32'h5555; s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_bvalid !== 1'b1) bad_bvalid = 1;
      if (s_awready !== 1'b0 || s_wready !== 1'b0) bad_ready = 1;
      if (i == 0 && (o_dds_write !== 1'b1 || o_dds_addrs !== 32'd2)) bad_first = 1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (bad_bvalid) begin errs++; $display("FAIL w_leads_bvalid: bvalid dropped while bready low, required held 1"); end
    vecs++;
    if (bad_ready) begin errs++; $display("FAIL w_leads_ready: READY high during W_RESP, required 0"); end
    vecs++;
    if (bad_first) begin errs++; $display("FAIL w_leads_push: first resp cycle write/addrs not 1/2, required 1/2"); end
    vecs++;
    if (push_cnt - p0 !== 1 || o_dds_ampls_reg !== 32'h7FFF || o_dds_thetas_reg !== 32'h00BB_12DD) begin
      errs++; $display("FAIL w_leads_single: pulses=%0d ampls=%h thetas=%h, required 1/00007fff/00bb12dd",
                       push_cnt - p0, o_dds_ampls_reg, o_dds_thetas_reg);
    end
  endtask

  task automatic test_start_block();
    logic [1:0] r; logic wr; logic [31:0] idx, d; int p0, h0;
    axi_write(8'h08, 32'h55, 4'hF, r, wr, idx);
    axi_write(8'h00, 32'h2, 4'hF, r, wr, idx);
    p0 = push_cnt;
    axi_write(8'h08, 32'hDEAD, 4'hF, r, wr, idx);
    vecs++;
    if (r !== 2'b10 || wr !== 1'b0 || push_cnt !== p0) begin
      errs++; $display("FAIL start_block_resp: resp=%b write=%b pulses=%0d, required 10/0/0", r, wr, push_cnt - p0);
    end
    axi_read(8'h08, d, r);
    vecs++;
    if (d !== 32'h55) begin errs++; $display("FAIL start_block_deltas: data=%h, required 00000055", d); end
    axi_read(8'h14, d, r);
    vecs++;
    if (d !== 32'h8010_0402) begin errs++; $display("FAIL start_status: data=%h, required 80100402", d); end
    h0 = rst_hi_cnt;
    axi_write(8'h00, 32'h1, 4'hF, r, wr, idx);
    repeat (3) @(negedge clk);
    vecs++;
    if (rst_hi_cnt - h0 !== 1) begin
      errs++; $display("FAIL ctrl_rst_pulse: ctrl[0] high for %0d cycles, required 1", rst_hi_cnt - h0);
    end
    axi_read(8'h14, d, r);
    vecs++;
    if (d !== 32'h0) begin errs++; $display("FAIL rst_status: data=%h, required 0", d); end
    axi_read(8'h00, d, r);
    vecs++;
    if (d !== 32'h0 || r !== 2'b00) begin errs++; $display("FAIL rst_ctrl_read: data=%h resp=%b, required 0/00", d, r); end
  endtask

  task automatic test_saturation();
    logic [1:0] r; logic wr; logic [31:0] idx, d; int p0, bad;
    p0 = push_cnt; bad = 0;
    for (int i = 0; i < 600; i++) begin
      axi_write(8'h08, i, 4'hF, r, wr, idx);
      if (r !== 2'b00 || wr !== 1'b1 || idx !== 32'd1) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL sat_writes: %0d writes not OKAY/pushed/idx1, required 0", bad); end
    vecs++;
    if (push_cnt - p0 !== 600 || o_dds_deltas_reg !== 32'd599) begin
      errs++; $display("FAIL sat_pulses: pulses=%0d deltas=%0d, required 600/599", push_cnt - p0, o_dds_deltas_reg);
    end
    axi_read(8'h14, d, r);
    vecs++;
    if (d !== 32'h0008_0000) begin
      errs++; $display("FAIL sat_status: data=%h (deltas=%0d), required 00080000 (512)", d, d[19:10]);
    end
  endtask

  task automatic test_timer();
    logic [1:0] r; logic wr; logic [31:0] idx; int t0, t1, t2, t3, t4, n; bit ok;
    axi_write(8'h18, 32'd4, 4'hF, r, wr, idx);
    axi_write(8'h00, 32'h2, 4'hF, r, wr, idx);
    wait_pulse(t0, ok);
    wait_pulse(t1, ok);
    wait_pulse(t2, ok);
    vecs++;
    if (t1 - t0 !== 5 || t2 - t1 !== 5) begin
      errs++; $display("FAIL timer_div4: intervals %0d,%0d, required 5,5", t1 - t0, t2 - t1);
    end
    // Commit DIV=1 on the edge where the count wraps to 0.
    s_awaddr = 8'h18; s_wdata = 32'd1; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_pulse(t3, ok);
    wait_pulse(t4, ok);
    vecs++;
    if (t3 - t2 !== 2 || t4 - t3 !== 2) begin
      errs++; $display("FAIL timer_div1: intervals %0d,%0d, required 2,2", t3 - t2, t4 - t3);
    end
    axi_write(8'h00, 32'h0, 4'hF, r, wr, idx);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_dds_sample_en) n++;
    end
    vecs++;
    if (n != 0) begin errs++; $display("FAIL timer_stop: %0d pulses with start=0, required 0", n); end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic wr; logic [31:0] idx, d;
    axi_read(8'h1C, d, r);
    vecs++;
    if (d !== 32'h0 || r !== 2'b10) begin errs++; $display("FAIL unmapped_read: data=%h resp=%b, required 0/10", d, r); end
    axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, r, wr, idx);
    vecs++;
    if (r !== 2'b10 || wr !== 1'b0) begin errs++; $display("FAIL status_write: resp=%b write=%b, required 10/0", r, wr); end
    axi_write(8'h1C, 32'h1234, 4'hF, r, wr, idx);
    vecs++;
    if (r !== 2'b10 || wr !== 1'b0) begin errs++; $display("FAIL unmapped_write: resp=%b write=%b, required 10/0", r, wr); end
    axi_read(8'h14, d, r);
    vecs++;
    if (d !== 32'h0008_0000) begin errs++; $display("FAIL status_after_err: data=%h, required 00080000", d); end
  endtask

  task automatic test_read_race();
    logic [31:0] d; logic [1:0] r;
    @(posedge clk); #1;
    s_awaddr = 8'h10; s_wdata = 32'd256; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 8'h10; s_arvalid = 1'b1;
    @(negedge clk);
    vecs++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errs++; $display("FAIL race_ready: aw/w/ar ready=%b, required 111", {s_awready, s_wready, s_arready});
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge clk);
    vecs++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'h0 || s_rresp !== 2'b00 || s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errs++; $display("FAIL race_old_value: rvalid=%b rdata=%h rresp=%b bvalid=%b, required 1/0/00/1",
                       s_rvalid, s_rdata, s_rresp, s_bvalid);
    end
    @(posedge clk); #1;
    axi_read(8'h10, d, r);
    vecs++;
    if (d !== 32'd256) begin errs++; $display("FAIL race_new_value: data=%h, required 00000100", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    s_rready = 1'b0;
    @(posedge clk); #1 s_araddr = 8'h18; s_arvalid = 1'b1;
    @(posedge clk); #1 s_arvalid = 1'b0;
    @(negedge clk);
    vecs++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'd1) begin
      errs++; $display("FAIL mid_read: rvalid=%b rdata=%h, required 1/00000001", s_rvalid, s_rdata);
    end
    a_rst_n = 1'b0;
    #1;
    vecs++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b0) begin
      errs++; $display("FAIL mid_reset_abort: rvalid=%b arready=%b, required 0/0", s_rvalid, s_arready);
    end
    @(negedge clk);
    vecs++;
    if ((o_dds_lngth_reg | o_dds_thetas_reg | o_dds_deltas_reg | o_dds_ampls_reg | o_dds_ctrl_reg) !== 32'h0) begin
      errs++; $display("FAIL mid_reset_regs: ln=%h th=%h de=%h am=%h ctrl=%h, required all 0",
                       o_dds_lngth_reg, o_dds_thetas_reg, o_dds_deltas_reg, o_dds_ampls_reg, o_dds_ctrl_reg);
    end
    @(posedge clk); #1 a_rst_n = 1'b1; s_rready = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(8'h18, d, r);
    vecs++;
    if (d !== 32'd1023) begin errs++; $display("FAIL mid_reset_div: data=%h, required 000003ff", d); end
    axi_read(8'h14, d, r);
    vecs++;
    if (d !== 32'h0) begin errs++; $display("FAIL mid_reset_status: data=%h, required 0", d); end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_leads();
    test_start_block();
    test_saturation();
    test_timer();
    test_errors();
    test_read_race();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dds_axil_regs.md
Name: dds_axil_regs

Overview:
- AXI4-Lite slave that owns the DDS register map and drives the DDS core's bus interface: register values, write strobe/address, and the sample-enable timer.
- Sits between the processor interconnect and the DDS core.
- Turns CPU writes to the THETAS/DELTAS/AMPLS data registers into single-cycle push pulses into the core's circular buffers.
- Generates the periodic sample-enable pulse and exposes push counters and status for readback.

Parameters:
- ADDR_WIDTH, 8, AXI address width; decode uses bits [ADDR_WIDTH-1:2], bits [1:0] ignored.
- DIV_RESET, 1023, reset value of the sample divider register.
- CNT_MAX, 512, saturation value of the per-buffer push counters.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  reset, asynchronous, active-low
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid / s_awready  in / out  1  write-address handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables
- s_wvalid / s_wready  in / out  1  write-data handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  write-response handshake
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid / s_arready  in / out  1  read-address handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  read-data handshake
- o_dds_addrs  out  32  buffer index: 0=THETAS, 1=DELTAS, 2=AMPLS
- o_dds_write  out  1  one-cycle push strobe
- o_dds_ctrl_reg, o_dds_thetas_reg, o_dds_deltas_reg, o_dds_ampls_reg, o_dds_lngth_reg  out  32 each  register contents
- o_dds_sample_en  out  1  sample pulse

Behaviour:
- Reset: all registers 0 except DIV=DIV_RESET. All outputs 0; READY outputs are 0 during reset.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 rst, bit1 start.
  - 0x04 THETAS, 0x08 DELTAS, 0x0C AMPLS, 0x10 LNGTH, 0x18 DIV: all RW.
  - 0x14 STATUS (RO): [9:0] thetas push count, [19:10] deltas count, [29:20] ampls count, [31] start.
  - Any other offset: RDATA=0, RESP=SLVERR (2'b10), no side effect.
- CTRL.rst is self-clearing: it is high on o_dds_ctrl_reg[0] for exactly one cycle after the write commits, and reads back as 0. A rst commit clears all three push counters and the timer count.
- Write FSM (W_IDLE, W_RESP):
  - In W_IDLE, s_awready=1 until AW is latched and s_wready=1 until W is latched; AW and W may arrive in the same cycle or in either order.
  - The edge after both are latched is the commit edge: apply the register write (merge per s_wstrb), set s_bvalid=1, go to W_RESP.
  - In W_RESP, both READYs are 0. Hold s_bvalid until s_bready, then return to W_IDLE.
  - One write is outstanding at most.
- Push pulse, on a commit to THETAS, DELTAS or AMPLS while CTRL.start=0:
  - o_dds_write=1 for exactly the cycle following the commit edge, with o_dds_addrs set to the index.
  - The matching o_dds_*_reg already holds the new value in that cycle.
  - The matching counter increments, saturating at CNT_MAX.
  - The response is OKAY.
- The same data-register writes while CTRL.start=1 return SLVERR: register unchanged, no pulse, no count.
- Writing 0x14 (RO) returns SLVERR with no effect.
- Read FSM (R_IDLE, R_DATA):
  - In R_IDLE, s_arready=1. On handshake, capture data, set s_rvalid=1 the next cycle, go to R_DATA.
  - Hold s_rvalid and s_rdata until s_rready; s_arready=0 in R_DATA.
  - If a read handshake and a write commit occur on the same edge to the same register, the read returns the pre-write value.
- Sample timer (sub-module):
  - Runs only while CTRL.start=1. It counts 0..DIV and pulses o_dds_sample_en for one cycle when count==DIV, then wraps to 0. The period is DIV+1 cycles; DIV=0 gives a pulse every cycle.
  - start=0 holds the count at 0 with no pulse.
  - Writing DIV mid-run takes effect at the next compare; if the new DIV is below the current count, the count wraps at 2^32.
- Asserting a_rst_n mid-transaction aborts any AXI transaction in flight (VALIDs drop to 0) and drops any pending push.

Decomposition:
- Package dds_regs_pkg holds:
  - address offset constants;
  - buffer index constants THETAS=0, DELTAS=1, AMPLS=2;
  - CTRL_RST_BIT=0, CTRL_STRT_BIT=1;
  - AXI response codes OKAY / SLVERR;
  - write and read FSM state enums.
- Sub-module dds_sample_timer: inputs clk, a_rst_n, clr, en, div[31:0]; output pulse.

Test Plan:
- AW and W in the same cycle: write 0x04 = 0x0000_1234 -> s_bvalid the next cycle with OKAY; that same cycle o_dds_write=1, o_dds_addrs=0, o_dds_thetas_reg=0x1234; STATUS[9:0]=1.
- W leads AW by 3 cycles: write 0x0C = 0x7FFF with s_bready held low 5 cycles -> a single o_dds_write pulse with o_dds_addrs=2; s_bvalid held through all 5 cycles; no second write accepted meanwhile.
- Start blocking: write CTRL=0x2, then write 0x08 -> SLVERR, no pulse, DELTAS reads back the old value. Then write CTRL=0x1 -> o_dds_ctrl_reg[0] high for 1 cycle, STATUS=0, CTRL reads back 0.
- Saturation: 600 writes to 0x08 with start=0 -> STATUS[19:10]=512 and 600 push pulses.
- Timer: DIV=4, start=1 -> o_dds_sample_en every 5 cycles. Write DIV=1 mid-run -> period becomes 2. start=0 -> no pulses.
- Error and race cases:
  - read 0x1C -> RDATA=0, SLVERR;
  - read 0x10 on the same edge as a write commit of 0x10=256 -> returns the old 0, a subsequent read returns 256;
  - a_rst_n pulsed while s_rvalid=1 -> s_rvalid drops to 0 and all registers return to reset values.
